// File: rtl/memory_access_pkg.sv
// memory_access_pkg: shared types and constants for the memory stage.
//   state_t         : FSM states of the memory stage
//   ALIGN_BITS      : low address bits that must be zero (doubleword accesses)
//   DEFAULT_TIMEOUT : default ACCESS cycles allowed before aborting
package memory_access_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam int ALIGN_BITS      = 3;
  localparam int DEFAULT_TIMEOUT = 16;
endpackage

// File: rtl/memory_access_timeout.sv
// timeout_counter: free-running up counter with synchronous clear and enable.
//   clk, reset : clock and synchronous active-high reset
//   i_clr      : synchronous clear (wins over i_en)
//   i_en       : count enable
//   o_tc       : high while the count equals TC
module timeout_counter #(
  parameter int           W  = 4,
  parameter logic [W-1:0] TC = '1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr) r_cnt <= '0;
    else if (i_en)      r_cnt <= r_cnt + 1'b1;
  end

  assign o_tc = (r_cnt == TC);
endmodule

// File: rtl/memory_access.sv
// memory_access: multi-cycle memory stage between execute and writeback.
// Accepts execute results in IDLE, runs one doubleword load/store over a
// req/ack handshake, resolves the branch, and stalls the core meanwhile.
// Misaligned, illegal (read+write) and timed-out accesses raise error_M.
//   clk, reset                        : clock, synchronous active-high reset
//   valid_E, Branch, memRead, memWrite: execute-stage control
//   PCBranch_E, aluResult_E, writeData_E, zero_E : execute results
//   ready_M, stall_M                  : stage ready / core stall
//   dm_req, dm_we, dm_addr, dm_wdata  : data memory request (registered)
//   dm_ack, dm_rdata                  : data memory completion
//   done_M                            : one-cycle completion pulse
//   readData_M, aluResult_M, PCBranch_M, PCSrc_M, error_M : results
module memory_access
  import memory_access_pkg::*;
#(
  parameter int N       = 64,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_E,
  input  logic         Branch,
  input  logic         memRead,
  input  logic         memWrite,
  input  logic [N-1:0] PCBranch_E,
  input  logic [N-1:0] aluResult_E,
  input  logic [N-1:0] writeData_E,
  input  logic         zero_E,
  output logic         ready_M,
  output logic         stall_M,
  output logic         dm_req,
  output logic         dm_we,
  output logic [N-1:0] dm_addr,
  output logic [N-1:0] dm_wdata,
  input  logic         dm_ack,
  input  logic [N-1:0] dm_rdata,
  output logic         done_M,
  output logic [N-1:0] readData_M,
  output logic [N-1:0] aluResult_M,
  output logic [N-1:0] PCBranch_M,
  output logic         PCSrc_M,
  output logic         error_M
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t r_state;
  logic   r_load;
  logic   w_tc;
  logic   w_mem_op;
  logic   w_misaligned;

  assign w_mem_op     = memRead | memWrite;
  assign w_misaligned = |aluResult_E[ALIGN_BITS-1:0];

  // Counter idles at zero outside ACCESS, so every access starts from 0.
  // Terminal count at TIMEOUT-1 gives exactly TIMEOUT request cycles.
  timeout_counter #(
    .W  (CW),
    .TC (CW'(TIMEOUT - 1))
  ) u_tmo (
    .clk   (clk),
    .reset (reset),
    .i_clr (r_state != ACCESS),
    .i_en  (!dm_ack),
    .o_tc  (w_tc)
  );

  // Status outputs decode straight from the state register: no path from
  // dm_ack reaches dm_req combinationally.
  assign ready_M = (r_state == IDLE);
  assign stall_M = ~ready_M;
  assign dm_req  = (r_state == ACCESS);
  assign done_M  = (r_state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_load      <= 1'b0;
      dm_we       <= 1'b0;
      dm_addr     <= '0;
      dm_wdata    <= '0;
      readData_M  <= '0;
      aluResult_M <= '0;
      PCBranch_M  <= '0;
      PCSrc_M     <= 1'b0;
      error_M     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (valid_E) begin
          PCSrc_M     <= Branch & zero_E;
          aluResult_M <= aluResult_E;
          PCBranch_M  <= PCBranch_E;
          dm_addr     <= aluResult_E;
          dm_wdata    <= writeData_E;
          dm_we       <= memWrite;
          r_load      <= memRead;
          if (memRead && memWrite) begin
            error_M <= 1'b1;
            r_state <= DONE;
          end else if (w_mem_op && w_misaligned) begin
            error_M <= 1'b1;
            r_state <= DONE;
          end else if (w_mem_op) begin
            error_M <= 1'b0;
            r_state <= ACCESS;
          end else begin
            error_M <= 1'b0;
            r_state <= DONE;
          end
        end
        ACCESS: begin
          // Ack takes priority: an ack on the terminal cycle is a success.
          if (dm_ack) begin
            if (r_load) readData_M <= dm_rdata;
            r_state <= DONE;
          end else if (w_tc) begin
            error_M <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;
  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_E, Branch, memRead, memWrite, zero_E;
  logic [N-1:0] PCBranch_E, aluResult_E, writeData_E;
  logic         ready_M, stall_M, dm_req, dm_we, dm_ack, done_M;
  logic [N-1:0] dm_addr, dm_wdata, dm_rdata;
  logic [N-1:0] readData_M, aluResult_M, PCBranch_M;
  logic         PCSrc_M, error_M;

  int total = 0;
  int bad   = 0;

  memory_access #(.N(N), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .valid_E(valid_E), .Branch(Branch),
    .memRead(memRead), .memWrite(memWrite), .PCBranch_E(PCBranch_E),
    .aluResult_E(aluResult_E), .writeData_E(writeData_E), .zero_E(zero_E),
    .ready_M(ready_M), .stall_M(stall_M), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
    .dm_rdata(dm_rdata), .done_M(done_M), .readData_M(readData_M),
    .aluResult_M(aluResult_M), .PCBranch_M(PCBranch_M), .PCSrc_M(PCSrc_M),
    .error_M(error_M)
  );

  always #5 clk = ~clk;

  // Present one instruction for a single sampling edge k; returns at the
  // negedge inside cycle k+1.
  task automatic issue(input logic br, input logic rd, input logic wr,
                       input logic z, input logic [N-1:0] pcb,
                       input logic [N-1:0] alu, input logic [N-1:0] wd);
    @(negedge clk);
    valid_E = 1'b1; Branch = br; memRead = rd; memWrite = wr; zero_E = z;
    PCBranch_E = pcb; aluResult_E = alu; writeData_E = wd;
    @(negedge clk);
    valid_E = 1'b0; Branch = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    zero_E = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (ready_M !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", ready_M); end
    total++; if (stall_M !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall_M); end
    total++; if ({dm_req, done_M, error_M, PCSrc_M, dm_we} !== 5'b0) begin bad++; $display("FAIL rst_flags got=%b exp=00000", {dm_req, done_M, error_M, PCSrc_M, dm_we}); end
    total++; if ((readData_M | aluResult_M | PCBranch_M | dm_addr | dm_wdata) !== '0) begin bad++; $display("FAIL rst_data got nonzero exp=0"); end
    reset = 1'b0;
  endtask

  task automatic test_rtype;
    issue(1'b1, 1'b0, 1'b0, 1'b1, 64'h100, 64'd42, 64'h0);
    total++; if (done_M !== 1'b1) begin bad++; $display("FAIL rtype_done got=%b exp=1", done_M); end
    total++; if (dm_req !== 1'b0) begin bad++; $display("FAIL rtype_req got=%b exp=0", dm_req); end
    total++; if (aluResult_M !== 64'd42) begin bad++; $display("FAIL rtype_alu got=%h exp=2a", aluResult_M); end
    total++; if (PCSrc_M !== 1'b1) begin bad++; $display("FAIL rtype_pcsrc got=%b exp=1", PCSrc_M); end
    total++; if (PCBranch_M !== 64'h100) begin bad++; $display("FAIL rtype_pcb got=%h exp=100", PCBranch_M); end
    total++; if (stall_M !== 1'b1) begin bad++; $display("FAIL rtype_stall got=%b exp=1", stall_M); end
    @(negedge clk);
    total++; if ({ready_M, done_M} !== 2'b10) begin bad++; $display("FAIL rtype_ready got=%b exp=10", {ready_M, done_M}); end
  endtask

  task automatic test_load;
    issue(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h40, 64'h0);
    for (int i = 0; i < 3; i++) begin
      total++; if ({dm_req, dm_we, done_M} !== 3'b100 || dm_addr !== 64'h40) begin
        bad++; $display("FAIL load_req%0d got req/we/done=%b addr=%h exp=100 addr=40", i, {dm_req, dm_we, done_M}, dm_addr);
      end
      if (i == 2) begin dm_ack = 1'b1; dm_rdata = 64'hDEADBEEF; end
      @(negedge clk);
    end
    dm_ack = 1'b0; dm_rdata = '0;
    total++; if (done_M !== 1'b1 || dm_req !== 1'b0) begin bad++; $display("FAIL load_done got done/req=%b%b exp=10", done_M, dm_req); end
    total++; if (readData_M !== 64'hDEADBEEF) begin bad++; $display("FAIL load_data got=%h exp=deadbeef", readData_M); end
    total++; if (error_M !== 1'b0) begin bad++; $display("FAIL load_err got=%b exp=0", error_M); end
    @(negedge clk);
  endtask

  task automatic test_store;
    issue(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 64'h18, 64'd7);
    total++; if (dm_req !== 1'b1 || dm_we !== 1'b1 || dm_wdata !== 64'd7 || dm_addr !== 64'h18) begin
      bad++; $display("FAIL store_req got req=%b we=%b wdata=%h addr=%h exp 1 1 7 18", dm_req, dm_we, dm_wdata, dm_addr);
    end
    dm_ack = 1'b1; dm_rdata = 64'h1234;
    @(negedge clk);
    dm_ack = 1'b0; dm_rdata = '0;
    total++; if (done_M !== 1'b1) begin bad++; $display("FAIL store_done got=%b exp=1", done_M); end
    total++; if (readData_M !== 64'hDEADBEEF) begin bad++; $display("FAIL store_rdata got=%h exp=deadbeef", readData_M); end
    total++; if (error_M !== 1'b0) begin bad++; $display("FAIL store_err got=%b exp=0", error_M); end
    @(negedge clk);
  endtask

  task automatic test_misaligned;
    issue(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h44, 64'h0);
    total++; if ({dm_req, done_M, error_M} !== 3'b011) begin bad++; $display("FAIL misalign got req/done/err=%b exp=011", {dm_req, done_M, error_M}); end
    total++; if (aluResult_M !== 64'h44) begin bad++; $display("FAIL misalign_alu got=%h exp=44", aluResult_M); end
    @(negedge clk);
  endtask

  task automatic test_illegal;
    issue(1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 64'h48, 64'h5);
    total++; if ({dm_req, done_M, error_M} !== 3'b011) begin bad++; $display("FAIL illegal got req/done/err=%b exp=011", {dm_req, done_M, error_M}); end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int  req_cycles = 0;
    bit  seen_done  = 0;
    issue(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h80, 64'h0);
    for (int i = 0; i < 40 && !seen_done; i++) begin
      if (done_M) seen_done = 1;
      else begin
        if (dm_req) req_cycles++;
        @(negedge clk);
      end
    end
    total++; if (!seen_done) begin bad++; $display("FAIL tmo_done no done_M within 40 cycles"); end
    total++; if (req_cycles != 16) begin bad++; $display("FAIL tmo_len got=%0d exp=16", req_cycles); end
    total++; if (error_M !== 1'b1) begin bad++; $display("FAIL tmo_err got=%b exp=1", error_M); end
    total++; if (readData_M !== 64'hDEADBEEF) begin bad++; $display("FAIL tmo_rdata got=%h exp=deadbeef", readData_M); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    // A clean op after an error clears error_M; Branch with zero_E=0 gives PCSrc=0.
    issue(1'b1, 1'b0, 1'b0, 1'b0, 64'h200, 64'd9, 64'h0);
    total++; if ({done_M, error_M, PCSrc_M} !== 3'b100) begin bad++; $display("FAIL b2b_flags got done/err/pcsrc=%b exp=100", {done_M, error_M, PCSrc_M}); end
    total++; if (PCBranch_M !== 64'h200) begin bad++; $display("FAIL b2b_pcb got=%h exp=200", PCBranch_M); end
    @(negedge clk);
  endtask

  task automatic test_reset_in_access;
    issue(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h40, 64'h0);
    @(negedge clk);
    total++; if (dm_req !== 1'b1) begin bad++; $display("FAIL rsta_req2 got=%b exp=1", dm_req); end
    reset = 1'b1;
    @(negedge clk);
    total++; if ({dm_req, done_M, ready_M} !== 3'b001) begin bad++; $display("FAIL rsta_flags got req/done/ready=%b exp=001", {dm_req, done_M, ready_M}); end
    total++; if ((readData_M | aluResult_M | PCBranch_M | dm_addr) !== '0 || {error_M, PCSrc_M} !== 2'b0) begin bad++; $display("FAIL rsta_clear got nonzero outputs exp=0"); end
    reset = 1'b0;
    @(negedge clk);
    total++; if ({done_M, ready_M} !== 2'b01) begin bad++; $display("FAIL rsta_after got done/ready=%b exp=01", {done_M, ready_M}); end
  endtask

  initial begin
    reset = 1'b1; valid_E = 1'b0; Branch = 1'b0; memRead = 1'b0;
    memWrite = 1'b0; zero_E = 1'b0; PCBranch_E = '0; aluResult_E = '0;
    writeData_E = '0; dm_ack = 1'b0; dm_rdata = '0;
    test_reset();
    test_rtype();
    test_load();
    test_store();
    test_misaligned();
    test_illegal();
    test_timeout();
    test_back_to_back();
    test_reset_in_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
